// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: a shift-add multiplier or restoring divider
// with a fixed WIDTH+2 cycle latency. Signed ops work on magnitudes, with the
// sign fixed up before the result is loaded.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, m_q, acc_hi_q, acc_lo_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q, done_q, dbz_q;

  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ok;
  logic [WIDTH-1:0] step_hi_d, step_lo_d;
  logic             neg_a, neg_b;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] fix_hi_d, fix_lo_d;
  logic             fix_dbz_d;

  // op[0]==0 selects the signed variants
  assign mag1 = (!op[0] && In1[WIDTH-1]) ? ('0 - In1) : In1;
  assign mag2 = (!op[0] && In2[WIDTH-1]) ? ('0 - In2) : In2;

  assign mul_sum   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? m_q : '0)};
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_ok    = (div_shift >= {1'b0, m_q});

  always_comb begin
    step_hi_d = acc_hi_q;
    step_lo_d = acc_lo_q;
    if (op_q[1]) begin
      // Partial remainder stays below the divisor, so the WIDTH-bit difference is exact
      step_hi_d = div_ok ? (div_shift[WIDTH-1:0] - m_q) : div_shift[WIDTH-1:0];
      step_lo_d = {acc_lo_q[WIDTH-2:0], div_ok};
    end else begin
      step_hi_d = mul_sum[WIDTH:1];
      step_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  assign neg_a    = !op_q[0] && a_q[WIDTH-1];
  assign neg_b    = !op_q[0] && b_q[WIDTH-1];
  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = (neg_a ^ neg_b) ? ('0 - prod) : prod;

  always_comb begin
    fix_hi_d  = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo_d  = prod_fix[WIDTH-1:0];
    fix_dbz_d = 1'b0;
    if (op_q[1]) begin
      if (b_q == '0) begin
        fix_hi_d  = a_q;
        fix_lo_d  = '1;
        fix_dbz_d = 1'b1;
      end else begin
        fix_hi_d = neg_a ? ('0 - acc_hi_q) : acc_hi_q;
        fix_lo_d = (neg_a ^ neg_b) ? ('0 - acc_lo_q) : acc_lo_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q     <= op;
            a_q      <= In1;
            b_q      <= In2;
            m_q      <= mag2;
            acc_hi_q <= '0;
            acc_lo_q <= mag1;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          // The cycle after the last step is spent in RUN so latency totals WIDTH+2
          if (cnt_q == CW'(WIDTH)) begin
            state_q <= FIX;
          end else begin
            acc_hi_q <= step_hi_d;
            acc_lo_q <= step_lo_d;
            cnt_q    <= cnt_q + CW'(1);
          end
        end
        FIX: begin
          hi_q    <= fix_hi_d;
          lo_q    <= fix_lo_d;
          dbz_q   <= fix_dbz_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32 with hand-computed results.
module tb_muldiv_unit;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] In1 = '0, In2 = '0;
  logic        flush = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int pulses;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .In1(In1), .In2(In2),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; In1 = a; In2 = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_done(input string tag, input logic [31:0] eh, input logic [31:0] el,
                           input logic ez);
    while (done !== 1'b1 && cyc < 100) tick();
    check({tag, ".lat"}, 64'(cyc), 64'd34);
    check({tag, ".hi"}, {32'h0, hi}, {32'h0, eh});
    check({tag, ".lo"}, {32'h0, lo}, {32'h0, el});
    check({tag, ".dbz"}, {63'h0, div_by_zero}, {63'h0, ez});
    check({tag, ".busy"}, {63'h0, busy}, 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input logic ez);
    issue(o, a, b);
    check({tag, ".busy_run"}, {63'h0, busy}, 64'd1);
    wait_done(tag, eh, el, ez);
    tick();
    check({tag, ".pulse"}, {63'h0, done}, 64'd0);
  endtask

  initial begin
    #2;
    check("rst.busy", {63'h0, busy}, 64'd0);
    check("rst.done", {63'h0, done}, 64'd0);
    check("rst.hi", {32'h0, hi}, 64'd0);
    check("rst.lo", {32'h0, lo}, 64'd0);
    check("rst.dbz", {63'h0, div_by_zero}, 64'd0);
    #5 reset = 1'b0;
    @(posedge clk);
    #1;

    run_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("mult_neg",  MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    run_op("div_neg",   DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("divu_zero", DIVU,  32'h0000000A, 32'h00000000, 32'h0000000A, 32'hFFFFFFFF, 1'b1);
    run_op("divu_10_3", DIVU,  32'h0000000A, 32'h00000003, 32'h00000001, 32'h00000003, 1'b0);
    run_op("div_wrap",  DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run_op("div_zero",  DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);
    run_op("div_7_m2",  DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    run_op("mult_mneg", MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
    run_op("multu_mix", MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0);

    // start while busy must be ignored
    issue(MULTU, 32'd2, 32'd3);
    repeat (4) tick();
    op = DIVU; In1 = 32'd7; In2 = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ignore", 32'd0, 32'd6, 1'b0);
    tick();

    // flush mid-operation: no done, results held
    issue(MULTU, 32'd5, 32'd5);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush.busy", {63'h0, busy}, 64'd0);
    check("flush.done", {63'h0, done}, 64'd0);
    pulses = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    check("flush.pulses", 64'(pulses), 64'd0);
    check("flush.hi", {32'h0, hi}, 64'd0);
    check("flush.lo", {32'h0, lo}, 64'd6);

    // asynchronous reset between edges during RUN
    issue(MULTU, 32'd3, 32'd3);
    repeat (5) tick();
    #2 reset = 1'b1;
    #1;
    check("areset.busy", {63'h0, busy}, 64'd0);
    check("areset.hi", {32'h0, hi}, 64'd0);
    check("areset.lo", {32'h0, lo}, 64'd0);
    check("areset.done", {63'h0, done}, 64'd0);
    reset = 1'b0;
    tick();
    check("areset.idle", {63'h0, busy}, 64'd0);

    // back-to-back: start while in DONE
    issue(MULTU, 32'd3, 32'd4);
    wait_done("b2b1", 32'd0, 32'd12, 1'b0);
    issue(MULTU, 32'd5, 32'd6);
    check("b2b.done_drop", {63'h0, done}, 64'd0);
    check("b2b.busy", {63'h0, busy}, 64'd1);
    wait_done("b2b2", 32'd0, 32'd30, 1'b0);
    tick();
    check("b2b.pulse", {63'h0, done}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
